// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a row of common-anode 7-segment digits.
// Feeds one shared BCD decoder and strobes anodes with a blank guard band per slot.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
  localparam int DW = 4 * NUM_DIGITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            load,
  input  logic [DW-1:0]   digits_in,
  input  logic            lz_en,
  output logic [3:0]      bin_out,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [IW-1:0]   digit_idx,
  output logic            frame_tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DW-1:0]          shadow_q, shadow_d;
  logic [DW-1:0]          pend_q, pend_d;
  logic                   pv_q, pv_d;
  logic [3:0]             bin_q, bin_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic                   tick_q, tick_d;

  logic                   slot_end;
  logic                   last_digit;
  logic                   boundary;
  logic [3:0]             sel_val;
  logic                   upper_nz;
  logic [3:0]             disp_val;

  assign slot_end   = (cnt_q == CW'(REFRESH_DIV - 1));
  assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));
  // The cycle that carries the scan from the last digit's SHOW into digit 0's BLANK.
  assign boundary   = enable && (state_q == SHOW) && slot_end && last_digit;

  // Display value of the digit about to be addressed, from the shadow it will see.
  always_comb begin
    sel_val  = 4'h0;
    upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_d) begin
        sel_val = shadow_d[4*i +: 4];
      end
      if ((IW'(i) >= idx_d) && (shadow_d[4*i +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
    if (lz_en && (idx_d != '0) && !upper_nz) begin
      disp_val = 4'hF;
    end else begin
      disp_val = sel_val;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pv_d     = pv_q;
    tick_d   = 1'b0;

    if (load) begin
      pend_d = digits_in;
      pv_d   = 1'b1;
    end
    // A load on the boundary cycle itself is already in pend_d, giving the bypass.
    if (((state_q == IDLE) || boundary) && pv_d) begin
      shadow_d = pend_d;
      pv_d     = 1'b0;
    end

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (slot_end) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = last_digit ? '0 : idx_q + IW'(1);
            tick_d  = last_digit;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered copies derived from the next state.
  always_comb begin
    an_d  = '1;
    bin_d = 4'hF;
    case (state_d)
      BLANK: bin_d = disp_val;
      SHOW: begin
        an_d[idx_d] = 1'b0;
        bin_d       = bin_q;
      end
      default: begin
        an_d  = '1;
        bin_d = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      pend_q   <= '0;
      pv_q     <= 1'b0;
      bin_q    <= 4'hF;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pv_q     <= pv_d;
      bin_q    <= bin_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign bin_out    = bin_q;
  assign an_n       = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule
